// File: rtl/shift_seq2x4.sv
// shift_seq2x4: sequential multi-step shifter for two nibbles with valid/ready handshake
module shift_seq2x4 #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             dir,
    input  logic             arith,
    input  logic [CNT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ya,
    output logic [3:0]       yb,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             dir_q, arith_q;

    function automatic logic [3:0] step(input logic [3:0] x, input logic d, input logic ar);
        return d ? {ar & x[3], x[3:1]} : {x[2:0], 1'b0};
    endfunction

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    // next-state: accept in IDLE, count steps in SHIFT, wait for consumer in DONE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? ((amt == '0) ? DONE : SHIFT) : IDLE;
            SHIFT:   state_n = (cnt == CNT_W'(1)) ? DONE : SHIFT;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // datapath: capture operands on accept, apply one 1-bit step per SHIFT cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ya      <= '0;
            yb      <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            ya      <= a;
            yb      <= b;
            cnt     <= amt;
            dir_q   <= dir;
            arith_q <= arith;
        end else if (state == SHIFT) begin
            ya  <= step(ya, dir_q, arith_q);
            yb  <= step(yb, dir_q, arith_q);
            cnt <= cnt - 1'b1;
        end

    // status outputs are pure state decodes; in_ready is also held low during reset
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state == SHIFT) || (state == DONE);
    end
endmodule

// File: tb/tb_shift_seq2x4.sv
// tb_shift_seq2x4: directed and randomized checks of shift_seq2x4 against a closed-form shift model
module tb_shift_seq2x4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       dir = 1'b0;
    logic       arith = 1'b0;
    logic [2:0] amt = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] ya, yb;
    logic       busy;

    int checks = 0;
    int failures = 0;

    shift_seq2x4 #(.CNT_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .dir(dir), .arith(arith), .amt(amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .ya(ya), .yb(yb), .busy(busy)
    );

    always #5 clk = ~clk;

    // whole-amount shift in one go; signed >>> gives the sign-fill behaviour
    function automatic logic [3:0] model(input logic [3:0] x, input logic d, input logic ar, input int k);
        logic [7:0] w;
        logic signed [3:0] s;
        s = x;
        w = {4'b0, x} << k;
        if (!d) return w[3:0];
        if (ar) return s >>> k;
        return x >> k;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        in_valid = 1'($urandom);
        a = 4'($urandom);
        b = 4'($urandom);
        dir = 1'($urandom);
        arith = 1'($urandom);
        amt = 3'($urandom);
    endtask

    // one full transaction starting and ending at a negedge
    task automatic do_req(input logic [3:0] ta, input logic [3:0] tb, input logic td,
                          input logic tar, input int tamt, input int hold);
        int n;
        logic [3:0] ea, eb;
        ea = model(ta, td, tar, tamt);
        eb = model(tb, td, tar, tamt);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", 8'(in_ready), 8'd1);
        in_valid = 1'b1; a = ta; b = tb; dir = td; arith = tar; amt = 3'(tamt);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            scramble();
        end while (!out_valid && n < 20);
        chk("latency", 8'(n), 8'(tamt + 1));
        chk("ya", 8'(ya), 8'(ea));
        chk("yb", 8'(yb), 8'(eb));
        chk("busy_done", 8'(busy), 8'd1);
        chk("in_ready_done", 8'(in_ready), 8'd0);
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 8'(out_valid), 8'd1);
            chk("hold_ya", 8'(ya), 8'(ea));
            chk("hold_yb", 8'(yb), 8'(eb));
            chk("hold_in_ready", 8'(in_ready), 8'd0);
            scramble();
            in_valid = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("idle_valid", 8'(out_valid), 8'd0);
        chk("idle_in_ready", 8'(in_ready), 8'd1);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("keep_ya", 8'(ya), 8'(ea));
        chk("keep_yb", 8'(yb), 8'(eb));
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 8'(in_ready), 8'd0);
        chk("rst_valid", 8'(out_valid), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_ya", 8'(ya), 8'd0);
        chk("rst_yb", 8'(yb), 8'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 8'(in_ready), 8'd1);
        @(negedge clk);

        do_req(4'b1010, 4'b0111, 1'b1, 1'b1, 2, 0);
        chk("r032_ya", 8'(ya), 8'b1110);
        chk("r032_yb", 8'(yb), 8'b0001);
        do_req(4'b1111, 4'b0011, 1'b0, 1'b1, 3, 1);
        chk("r033_ya", 8'(ya), 8'b1000);
        chk("r033_yb", 8'(yb), 8'b1000);
        do_req(4'b1000, 4'b0111, 1'b1, 1'b1, 7, 0);
        chk("r034a_ya", 8'(ya), 8'b1111);
        chk("r034a_yb", 8'(yb), 8'b0000);
        do_req(4'b1000, 4'b0111, 1'b1, 1'b0, 7, 0);
        chk("r034l_ya", 8'(ya), 8'b0000);
        chk("r034l_yb", 8'(yb), 8'b0000);
        do_req(4'b0110, 4'b1001, 1'b0, 1'b0, 0, 0);
        chk("r035_ya", 8'(ya), 8'b0110);
        chk("r035_yb", 8'(yb), 8'b1001);
        do_req(4'b1101, 4'b0101, 1'b1, 1'b0, 1, 5);

        // abort mid-shift: accept amt=5, let two steps happen, then reset
        in_valid = 1'b1; a = 4'b1011; b = 4'b1100; dir = 1'b0; arith = 1'b0; amt = 3'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 8'(busy), 8'd1);
        chk("mid_ya", 8'(ya), 8'(model(4'b1011, 1'b0, 1'b0, 2)));
        rst = 1'b1;
        #1;
        chk("abort_ya", 8'(ya), 8'd0);
        chk("abort_yb", 8'(yb), 8'd0);
        chk("abort_valid", 8'(out_valid), 8'd0);
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_in_ready", 8'(in_ready), 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_stale_valid", 8'(out_valid), 8'd0);
        end
        do_req(4'b1001, 4'b0110, 1'b1, 1'b1, 3, 2);

        for (int i = 0; i < 30; i++)
            do_req(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
